mod_mul_interleaved: RTL and testbench

// - Sequential interleaved modular multiplier: outC = (a * b) mod p, fixed latency.
// - Downstream consumer of the BEEA inverter. a takes the inverter's outC (k^-1 mod p).
// - b takes a numerator x, so the pair forms a modular divider x/k mod p.
// - Same start/ready handshake style as the inverter: opselect starts, rdy high when idle.

---
 rtl/mod_mul_interleaved.sv | 121 ++++++++++++
 tb/tb_mod_mul_interleaved.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mod_mul_interleaved.sv
// Sequential interleaved modular multiplier: outC = (a * b) mod p.
// One multiplier bit is processed per clock, MSB first, with a fixed latency of WIDTH+1 edges.
module mod_mul_interleaved #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             opselect,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] outC,
    output logic             rdy,
    output logic             done,
    output logic             err
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int XW = WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [XW-1:0]    r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] outc_q, outc_d;
    logic             err_q, err_d;

    logic [XW-1:0]    a_ext, p_ext, t, t1, r_step;
    logic             in_bad;

    // R < P keeps 2R + A below 3*2^WIDTH, so WIDTH+2 bits never overflow.
    always_comb begin
        a_ext  = {2'b00, a_q};
        p_ext  = {2'b00, p_q};
        t      = (r_q << 1) + (b_q[cnt_q] ? a_ext : '0);
        t1     = (t >= p_ext) ? (t - p_ext) : t;
        r_step = (t1 >= p_ext) ? (t1 - p_ext) : t1;
    end

    assign in_bad = (p == '0) || (a >= p) || (b >= p);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        outc_d  = outc_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (opselect) begin
                    if (in_bad) begin
                        err_d   = 1'b1;
                        outc_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        a_d     = a;
                        b_d     = b;
                        p_d     = p;
                        r_d     = '0;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                r_d = r_step;
                if (cnt_q == '0) begin
                    outc_d  = r_step[WIDTH-1:0];
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            outc_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            outc_q  <= outc_d;
            err_q   <= err_d;
        end
    end

    assign outC = outc_q;
    assign rdy  = (state_q == S_IDLE);
    assign done = (state_q == S_DONE);
    assign err  = err_q;

endmodule

// File: tb/tb_mod_mul_interleaved.sv
// Bench for mod_mul_interleaved: directed and random operations against a 64-bit
// arithmetic reference, plus latency, handshake and reset checks.
module tb_mod_mul_interleaved;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        opselect;
    logic [31:0] a, b, p;
    logic [31:0] outC;
    logic        rdy, done, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mod_mul_interleaved #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opselect (opselect),
        .a        (a),
        .b        (b),
        .p        (p),
        .outC     (outC),
        .rdy      (rdy),
        .done     (done),
        .err      (err)
    );

    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] m);
        logic [63:0] prod;
        prod = 64'(x) * 64'(y);
        return 32'(prod % 64'(m));
    endfunction

    task automatic chk(input string op, input string what, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s/%s observed=%0h expected=%0h", op, what, obs, exp);
        end
    endtask

    // Start one operation, optionally pulsing opselect while busy, and check everything.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                          input logic [31:0] tp, input bit noise);
        logic        exp_err;
        logic [31:0] exp_out;
        int          exp_lat;
        int          lat;
        int          extra;
        exp_err = (tp == 0) || (ta >= tp) || (tbv >= tp);
        exp_out = exp_err ? 32'd0 : ref_mul(ta, tbv, tp);
        exp_lat = exp_err ? 1 : 33;

        @(negedge clk);
        a = ta; b = tbv; p = tp; opselect = 1'b1;
        @(posedge clk);
        @(negedge clk);
        opselect = 1'b0;
        a = $urandom; b = $urandom; p = $urandom;
        lat = 1;
        while (!done && lat < 100) begin
            opselect = noise && (lat % 7 == 3);
            a = $urandom; b = $urandom; p = $urandom;
            @(negedge clk);
            lat++;
        end
        opselect = 1'b0;
        chk(tag, "latency", 64'(lat), 64'(exp_lat));
        chk(tag, "outC", 64'(outC), 64'(exp_out));
        chk(tag, "err", 64'(err), 64'(exp_err));
        $display("op %s a=%0h b=%0h p=%0h -> outC=%0h err=%0b lat=%0d", tag, ta, tbv, tp,
                 outC, err, lat);

        opselect = noise;
        @(negedge clk);
        opselect = 1'b0;
        chk(tag, "rdy_after", 64'(rdy), 64'd1);
        chk(tag, "done_pulse_len", 64'(done), 64'd0);
        chk(tag, "outC_held", 64'(outC), 64'(exp_out));
        chk(tag, "err_held", 64'(err), 64'(exp_err));
        extra = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk(tag, "no_extra_done", 64'(extra), 64'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] rp, ra, rb;
        rst_n = 1'b0; opselect = 1'b0; a = '0; b = '0; p = '0;
        #12;
        chk("reset", "rdy", 64'(rdy), 64'd1);
        chk("reset", "done", 64'(done), 64'd0);
        chk("reset", "err", 64'(err), 64'd0);
        chk("reset", "outC", 64'(outC), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("T1_basic",   32'd3, 32'd5, 32'd7, 1'b0);
        run_op("T2_divide",  32'd5, 32'd4, 32'd7, 1'b0);
        run_op("T3_max",     32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFB, 1'b0);
        run_op("T4_b_zero",  32'h12345678, 32'd0, 32'hFFFFFFFB, 1'b0);
        run_op("T4_a_zero",  32'd0, 32'h0BADF00D, 32'hFFFFFFFB, 1'b0);
        run_op("p_one",      32'd0, 32'd0, 32'd1, 1'b0);
        run_op("even_p",     32'd999, 32'd12345, 32'd100000, 1'b0);
        run_op("T5_a_eq_p",  32'd7, 32'd1, 32'd7, 1'b0);
        run_op("T5_p_zero",  32'd0, 32'd0, 32'd0, 1'b0);
        run_op("T5_b_ge_p",  32'd1, 32'd9, 32'd7, 1'b0);
        run_op("T5_recover", 32'd2, 32'd3, 32'd7, 1'b0);
        run_op("T6_noise",   32'hDEADBEE, 32'h1234567, 32'hF0000001, 1'b1);

        // Abort an operation with reset partway through RUN.
        run_op("pre_reset",  32'd6, 32'd6, 32'd11, 1'b0);
        @(negedge clk);
        a = 32'd2; b = 32'd3; p = 32'd7; opselect = 1'b1;
        @(posedge clk);
        @(negedge clk);
        opselect = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset", "rdy", 64'(rdy), 64'd1);
        chk("midrun_reset", "outC", 64'(outC), 64'd0);
        chk("midrun_reset", "done", 64'(done), 64'd0);
        $display("op midrun_reset rdy=%0b outC=%0h done=%0b", rdy, outC, done);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("midrun_reset", "no_done_after", 64'(seen), 64'd0);
        run_op("restart",    32'd2, 32'd3, 32'd7, 1'b0);

        for (int i = 0; i < 20; i++) begin
            rp = (i % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
            if (rp == 0) rp = 32'd1;
            ra = (i % 6 == 5) ? rp : ($urandom % rp);
            rb = $urandom % rp;
            run_op($sformatf("rand%0d", i), ra, rb, rp, (i % 4 == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
